// File: rtl/switch_pkg.sv
// Shared switch types: default port count, payload width and packet bundle.
// Used by the switch fabric, the egress sinks and their benches.
package switch_pkg;

  localparam int NUM_PORTS  = 4;
  localparam int DATA_WIDTH = 8;

  typedef struct packed {
    logic [NUM_PORTS-1:0]  source;
    logic [NUM_PORTS-1:0]  target;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

endpackage

// File: rtl/rx_fifo.sv
// Packet FIFO for an egress sink; pointers carry one extra wrap bit
// so full and empty are told apart. Head reads as zero when empty.
module rx_fifo
  import switch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = pkt_t
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  T                           i_din,
  input  logic                       i_pop,
  output logic                       o_valid,
  output T                           o_dout,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  T           r_mem [DEPTH];
  logic [AW:0] r_wptr;
  logic [AW:0] r_rptr;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!w_full || w_pop);

  assign o_valid = !w_empty;
  assign o_full  = w_full;
  assign o_count = ($bits(o_count))'(r_wptr - r_rptr);
  assign o_dout  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= i_din;
    end
  end

  // Pointer advance on accepted push/pop, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

endmodule

// File: rtl/port_rx_sink.sv
// Egress sink of one switch port: filters, buffers, flags errors.
// Optional per-source counters enabled by PORT_RX_SINK_STATS_EN.
module port_rx_sink
  import switch_pkg::*;
#(
  parameter int PORT_ID    = 0,
  parameter int NUM_PORTS  = switch_pkg::NUM_PORTS,
  parameter int DATA_WIDTH = switch_pkg::DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            rx_valid,
  input  logic [NUM_PORTS-1:0]            rx_source,
  input  logic [NUM_PORTS-1:0]            rx_target,
  input  logic [DATA_WIDTH-1:0]           rx_data,
`ifdef PORT_RX_SINK_STATS_EN
  input  logic [$clog2(NUM_PORTS)-1:0]    stat_sel,
  output logic [15:0]                     stat_count,
`endif
  output logic                            pkt_valid,
  input  logic                            pkt_ready,
  output logic [NUM_PORTS-1:0]            pkt_source,
  output logic [NUM_PORTS-1:0]            pkt_target,
  output logic [DATA_WIDTH-1:0]           pkt_data,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow_err,
  output logic                            route_err,
  input  logic                            clear_err
);

  typedef struct packed {
    logic [NUM_PORTS-1:0]  source;
    logic [NUM_PORTS-1:0]  target;
    logic [DATA_WIDTH-1:0] data;
  } rx_pkt_t;

  rx_pkt_t w_din;
  rx_pkt_t w_head;
  logic    w_route_ok;
  logic    w_route_bad;
  logic    w_req;
  logic    w_pop;
  logic    w_full;
  logic    w_accept;
  logic    w_drop;
  logic    r_overflow_err;
  logic    r_route_err;

  assign w_din       = '{source: rx_source, target: rx_target, data: rx_data};
  assign w_route_ok  = rx_target[PORT_ID] && $onehot(rx_source);
  assign w_route_bad = rx_valid && !w_route_ok;
  assign w_req       = rx_valid && w_route_ok;
  assign w_pop       = pkt_valid && pkt_ready;
  assign w_accept    = w_req && (!w_full || w_pop);
  assign w_drop      = w_req && w_full && !w_pop;

  rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (rx_pkt_t)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_req),
    .i_din   (w_din),
    .i_pop   (pkt_ready),
    .o_valid (pkt_valid),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_count (fifo_count)
  );

  assign pkt_source   = w_head.source;
  assign pkt_target   = w_head.target;
  assign pkt_data     = w_head.data;
  assign overflow_err = r_overflow_err;
  assign route_err    = r_route_err;

  // Sticky error flags; a fresh error outranks a same-edge clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow_err <= 1'b0;
      r_route_err    <= 1'b0;
    end else begin
      r_overflow_err <= w_drop || (r_overflow_err && !clear_err);
      r_route_err    <= w_route_bad || (r_route_err && !clear_err);
    end
  end

`ifdef PORT_RX_SINK_STATS_EN
  logic [15:0] r_stat [NUM_PORTS];

  assign stat_count = r_stat[stat_sel];

  // Saturating accepted-packet count per originating port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PORTS; i++) r_stat[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (rx_source[i] && r_stat[i] != 16'hFFFF) begin
          r_stat[i] <= r_stat[i] + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_port_rx_sink.sv
// Bench for port_rx_sink (PORT_ID=3): directed scenarios then random
// traffic, all checked against a queue-based packet model.
module tb_port_rx_sink;

  localparam int NP = 4;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int PID = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_valid;
  logic [NP-1:0] rx_source;
  logic [NP-1:0] rx_target;
  logic [DW-1:0] rx_data;
  logic          pkt_valid;
  logic          pkt_ready;
  logic [NP-1:0] pkt_source;
  logic [NP-1:0] pkt_target;
  logic [DW-1:0] pkt_data;
  logic [2:0]    fifo_count;
  logic          overflow_err;
  logic          route_err;
  logic          clear_err;
  logic [1:0]    stat_sel;
`ifdef PORT_RX_SINK_STATS_EN
  logic [15:0]   stat_count;
`endif

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [NP-1:0] src;
    logic [NP-1:0] tgt;
    logic [DW-1:0] data;
  } m_pkt_t;

  m_pkt_t q[$];
  bit     m_rerr;
  bit     m_oerr;
  int     m_stat[NP];

  always #5 clk = ~clk;

  port_rx_sink #(
    .PORT_ID    (PID),
    .NUM_PORTS  (NP),
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_valid     (rx_valid),
    .rx_source    (rx_source),
    .rx_target    (rx_target),
    .rx_data      (rx_data),
`ifdef PORT_RX_SINK_STATS_EN
    .stat_sel     (stat_sel),
    .stat_count   (stat_count),
`endif
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_source   (pkt_source),
    .pkt_target   (pkt_target),
    .pkt_data     (pkt_data),
    .fifo_count   (fifo_count),
    .overflow_err (overflow_err),
    .route_err    (route_err),
    .clear_err    (clear_err)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    m_pkt_t h;
    bit     e;
    e = (q.size() == 0);
    if (!e) h = q[0];
    chk({tag, ".valid"}, 32'(pkt_valid), 32'(!e));
    chk({tag, ".count"}, 32'(fifo_count), 32'(q.size()));
    chk({tag, ".src"}, 32'(pkt_source), e ? 32'd0 : 32'(h.src));
    chk({tag, ".tgt"}, 32'(pkt_target), e ? 32'd0 : 32'(h.tgt));
    chk({tag, ".data"}, 32'(pkt_data), e ? 32'd0 : 32'(h.data));
    chk({tag, ".oerr"}, 32'(overflow_err), 32'(m_oerr));
    chk({tag, ".rerr"}, 32'(route_err), 32'(m_rerr));
`ifdef PORT_RX_SINK_STATS_EN
    chk({tag, ".stat"}, 32'(stat_count), 32'(m_stat[stat_sel]));
`endif
  endtask

  // Apply the packet rules to the model, clock the DUT, then compare.
  task automatic tick(string tag);
    bit     pop;
    bit     ok;
    m_pkt_t p;
    pop = (q.size() > 0) && pkt_ready;
    if (!rst_n) begin
      q.delete();
      m_rerr = 0;
      m_oerr = 0;
      foreach (m_stat[i]) m_stat[i] = 0;
    end else begin
      ok = rx_valid && rx_target[PID] && ($countones(rx_source) == 1);
      m_rerr = (m_rerr && !clear_err) || (rx_valid && !ok);
      m_oerr = m_oerr && !clear_err;
      if (ok && q.size() == DEPTH && !pop) m_oerr = 1;
      if (pop) void'(q.pop_front());
      if (ok && (q.size() < DEPTH)) begin
        p.src = rx_source;
        p.tgt = rx_target;
        p.data = rx_data;
        q.push_back(p);
        for (int i = 0; i < NP; i++)
          if (rx_source[i] && m_stat[i] < 16'hFFFF) m_stat[i]++;
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic rx(bit v, logic [NP-1:0] s, logic [NP-1:0] t,
                    logic [DW-1:0] d);
    rx_valid = v;
    rx_source = s;
    rx_target = t;
    rx_data = d;
  endtask

  initial begin
    rst_n = 1'b0;
    pkt_ready = 1'b0;
    clear_err = 1'b0;
    stat_sel = 2'd0;
    rx(0, 0, 0, 0);
    #1;
    tick("reset");
    chk("reset.count0", 32'(fifo_count), 32'd0);
    rst_n = 1'b1;

    // single packet, push into empty with ready high, then pop
    pkt_ready = 1'b1;
    rx(1, 4'b0001, 4'b1000, 8'hAB);
    tick("basic.push");
    chk("basic.data_ab", 32'(pkt_data), 32'hAB);
    rx(0, 0, 0, 0);
    tick("basic.pop");
    chk("basic.empty", 32'(fifo_count), 32'd0);

    // route error, clear, and error winning over a same-edge clear
    rx(1, 4'b0001, 4'b0101, 8'h55);
    tick("route.bad");
    chk("route.flag", 32'(route_err), 32'd1);
    rx(0, 0, 0, 0);
    clear_err = 1'b1;
    tick("route.clear");
    chk("route.cleared", 32'(route_err), 32'd0);
    rx(1, 4'b0011, 4'b1000, 8'h66);
    tick("route.winclr");
    chk("route.win", 32'(route_err), 32'd1);
    clear_err = 1'b0;

    // overflow: five packets into a four-deep FIFO with no consumer
    pkt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rx(1, 4'b0001, 4'b1000, 8'(8'h11 + i));
      tick("ovf.fill");
    end
    chk("ovf.count4", 32'(fifo_count), 32'd4);
    chk("ovf.flag", 32'(overflow_err), 32'd1);
    chk("ovf.head11", 32'(pkt_data), 32'h11);

    // full with simultaneous pop accepts the push
    pkt_ready = 1'b1;
    rx(1, 4'b0001, 4'b1000, 8'h16);
    tick("full.poppush");
    chk("full.count4", 32'(fifo_count), 32'd4);
    chk("full.head12", 32'(pkt_data), 32'h12);
    rx(0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick("drain");

    // broadcast from source 2
    stat_sel = 2'd2;
    rx(1, 4'b0100, 4'b1111, 8'h77);
    tick("bcast");
    chk("bcast.src", 32'(pkt_source), 32'h4);
    rx(0, 0, 0, 0);
    tick("bcast.pop");

    // reset while buffered, with traffic present during reset
    pkt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx(1, 4'b0010, 4'b1000, 8'(8'h20 + i));
      tick("rst.fill");
    end
    chk("rst.count3", 32'(fifo_count), 32'd3);
    rst_n = 1'b0;
    rx(1, 4'b0010, 4'b1000, 8'h99);
    tick("rst.apply");
    chk("rst.valid0", 32'(pkt_valid), 32'd0);
    rst_n = 1'b1;
    rx(0, 0, 0, 0);
    tick("rst.after");

    // random traffic
    for (int n = 0; n < 600; n++) begin
      logic [NP-1:0] s;
      logic [NP-1:0] t;
      if ($urandom_range(0, 3) != 0) s = 4'(1 << $urandom_range(0, 3));
      else s = 4'($urandom);
      t = 4'($urandom);
      if ($urandom_range(0, 9) < 7) t[PID] = 1'b1;
      rx(1'($urandom_range(0, 2) != 0), s, t, 8'($urandom));
      pkt_ready = 1'($urandom_range(0, 2) == 0);
      clear_err = 1'($urandom_range(0, 15) == 0);
      stat_sel = 2'($urandom);
      rst_n = ($urandom_range(0, 149) != 0);
      tick("rand");
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
